// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH/EXEC instruction cycle with pause, single-step and halt.
// Owns pc, ir and the retired-instruction counter; control decode drives jump/immediate hints.
module pc_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] romData,
   input  logic [7:0] dbus,
   input  logic       doJumpBar,
   input  logic       assertRom,
   input  logic       run,
   input  logic       step,
   output logic [7:0] ir,
   output logic [7:0] pc,
   output logic [7:0] romAddr,
   output logic       phaseExec,
   output logic       halted,
   output logic [7:0] retired
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      PAUSE = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t     state_reg;
   logic [7:0] pc_reg;
   logic [7:0] ir_reg;
   logic [7:0] retired_reg;
   logic       is_halt;

   assign is_halt = (ir_reg[6:4] == 3'b111);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= FETCH;
         pc_reg      <= 8'h00;
         ir_reg      <= 8'h00;
         retired_reg <= 8'h00;
      end else begin
         case (state_reg)
            FETCH: begin
               ir_reg    <= romData;
               pc_reg    <= pc_reg + 8'd1;
               state_reg <= EXEC;
            end
            EXEC: begin
               retired_reg <= retired_reg + 8'd1;
               if (is_halt) begin
                  state_reg <= HALT;
               end else begin
                  // Jump wins over the immediate-byte increment.
                  if (!doJumpBar)
                     pc_reg <= dbus;
                  else if (assertRom)
                     pc_reg <= pc_reg + 8'd1;
                  state_reg <= run ? FETCH : PAUSE;
               end
            end
            PAUSE: begin
               if (run || step)
                  state_reg <= FETCH;
            end
            HALT: begin
               state_reg <= HALT;
            end
         endcase
      end
   end

   assign ir        = ir_reg;
   assign pc        = pc_reg;
   assign romAddr   = pc_reg;
   assign retired   = retired_reg;
   assign phaseExec = (state_reg == EXEC);
   assign halted    = (state_reg == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle reference model feeding a scoreboard queue,
// plus directed scenario checks against fixed constants.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] romData;
   logic [7:0] dbus;
   logic       doJumpBar;
   logic       assertRom;
   logic       run;
   logic       step;
   logic [7:0] ir;
   logic [7:0] pc;
   logic [7:0] romAddr;
   logic       phaseExec;
   logic       halted;
   logic [7:0] retired;

   logic [7:0] rom [256];

   pc_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .romData   (romData),
      .dbus      (dbus),
      .doJumpBar (doJumpBar),
      .assertRom (assertRom),
      .run       (run),
      .step      (step),
      .ir        (ir),
      .pc        (pc),
      .romAddr   (romAddr),
      .phaseExec (phaseExec),
      .halted    (halted),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   assign romData = rom[romAddr];

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state: 0 FETCH, 1 EXEC, 2 PAUSE, 3 HALT
   logic [7:0] m_pc, m_ir, m_ret;
   int         m_st;
   bit         model_valid = 0;

   logic [25:0] sb [$];

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic tick(input bit jb, input bit ar, input bit r, input bit s,
                       input bit rs, input logic [7:0] db);
      logic [25:0] e;
      doJumpBar = jb; assertRom = ar; run = r; step = s; reset = rs; dbus = db;
      #1;
      if (model_valid)
         check("romaddr", romAddr, m_pc);
      if (rs) begin
         m_pc = 8'h00; m_ir = 8'h00; m_ret = 8'h00; m_st = 0;
         model_valid = 1;
      end else begin
         case (m_st)
            0: begin m_ir = rom[m_pc]; m_pc = m_pc + 8'd1; m_st = 1; end
            1: begin
               m_ret = m_ret + 8'd1;
               if (m_ir[6:4] == 3'b111) m_st = 3;
               else begin
                  if (!jb)     m_pc = db;
                  else if (ar) m_pc = m_pc + 8'd1;
                  m_st = r ? 0 : 2;
               end
            end
            2: if (r || s) m_st = 0;
            default: ;
         endcase
      end
      sb.push_back({m_pc, m_ir, m_ret, (m_st == 1), (m_st == 3)});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 8'h01, 8'h00);
      end else begin
         e = sb.pop_front();
         check("pc", pc, e[25:18]);
         check("ir", ir, e[17:10]);
         check("retired", retired, e[9:2]);
         check("phaseExec", {7'd0, phaseExec}, {7'd0, e[1]});
         check("halted", {7'd0, halted}, {7'd0, e[0]});
      end
   endtask

   logic [7:0] r0;

   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = 8'(i * 7);
         rom[i] = v & 8'hBF;   // bit 6 clear keeps filler bytes from being halts
      end
      rom[8'h00] = 8'h20;
      rom[8'h01] = 8'h30;
      rom[8'h40] = 8'h45;
      rom[8'h60] = 8'h70;

      doJumpBar = 1; assertRom = 0; run = 0; step = 0; reset = 1; dbus = 8'h00;
      @(negedge clk);
      tick(1, 0, 1, 0, 1, 8'h00);
      tick(0, 1, 1, 1, 1, 8'h55);   // low doJumpBar under reset must not move pc
      check("rst_pc", pc, 8'h00);
      check("rst_ir", ir, 8'h00);
      check("rst_ret", retired, 8'h00);
      check("rst_exec", {7'd0, phaseExec}, 8'h00);
      check("rst_halt", {7'd0, halted}, 8'h00);

      // Sequential fetch with no immediates
      tick(1, 0, 1, 0, 0, 8'h00);
      check("s1_ir20", ir, 8'h20);
      check("s1_pc01", pc, 8'h01);
      check("s1_exec", {7'd0, phaseExec}, 8'h01);
      tick(1, 0, 1, 0, 0, 8'h00);
      check("s1_hold", pc, 8'h01);
      tick(1, 0, 1, 0, 0, 8'h00);
      check("s1_ir30", ir, 8'h30);
      check("s1_pc02", pc, 8'h02);
      tick(1, 0, 1, 0, 0, 8'h00);
      check("s1_ret2", retired, 8'h02);

      // Jump beats immediate increment
      tick(1, 0, 1, 0, 0, 8'h00);
      tick(0, 0, 1, 0, 0, 8'h04);
      tick(1, 0, 1, 0, 0, 8'h00);
      check("s2_pc05", pc, 8'h05);
      tick(0, 1, 1, 0, 0, 8'h40);
      check("s2_jump", pc, 8'h40);
      tick(1, 0, 1, 0, 0, 8'h00);
      check("s2_ir", ir, 8'h45);
      check("s2_pc41", pc, 8'h41);

      // Wrap at 0xFF
      tick(0, 0, 1, 0, 0, 8'hFF);
      check("s3_ff", pc, 8'hFF);
      tick(1, 0, 1, 0, 0, 8'h00);
      check("s3_wrapf", pc, 8'h00);
      tick(0, 0, 1, 0, 0, 8'hFE);
      tick(1, 0, 1, 0, 0, 8'h00);
      check("s3_pcff", pc, 8'hFF);
      tick(1, 1, 1, 0, 0, 8'h00);
      check("s3_wrape", pc, 8'h00);

      // Pause and single step
      tick(1, 0, 1, 0, 0, 8'h00);
      tick(1, 0, 0, 1, 0, 8'h00);   // step in EXEC is ignored
      r0 = m_ret;
      for (int k = 0; k < 3; k++) begin
         tick(1, 0, 0, 0, 0, 8'h00);
         check("s4_pcheld", pc, 8'h01);
         check("s4_noexec", {7'd0, phaseExec}, 8'h00);
      end
      tick(1, 0, 0, 1, 0, 8'h00);
      tick(1, 0, 0, 0, 0, 8'h00);
      check("s4_ir", ir, 8'h30);
      check("s4_pc", pc, 8'h02);
      tick(1, 0, 0, 0, 0, 8'h00);
      check("s4_ret", retired, r0 + 8'd1);
      tick(1, 0, 0, 0, 0, 8'h00);
      tick(1, 0, 0, 0, 0, 8'h00);
      check("s4_paused", pc, 8'h02);
      check("s4_ret_h", retired, r0 + 8'd1);

      // Halt is absorbing
      tick(1, 0, 0, 1, 0, 8'h00);
      tick(1, 0, 0, 0, 0, 8'h00);
      tick(0, 0, 0, 0, 0, 8'h60);
      tick(1, 0, 0, 1, 0, 8'h00);
      tick(1, 0, 0, 0, 0, 8'h00);
      check("s5_ir70", ir, 8'h70);
      tick(0, 1, 1, 0, 0, 8'h11);
      check("s5_halted", {7'd0, halted}, 8'h01);
      check("s5_pc", pc, 8'h61);
      for (int k = 0; k < 4; k++) begin
         tick(k[0], 1, k[0], ~k[0], 0, 8'h22);
         check("s5_frozen", pc, 8'h61);
         check("s5_still", {7'd0, halted}, 8'h01);
      end
      tick(1, 0, 1, 0, 1, 8'h00);
      check("s5_unhalt", {7'd0, halted}, 8'h00);
      check("s5_pc0", pc, 8'h00);

      // Reset during EXEC with a pending jump
      tick(1, 0, 1, 0, 0, 8'h00);
      tick(0, 0, 1, 0, 1, 8'h99);
      check("s6_pc", pc, 8'h00);
      check("s6_fetch", {7'd0, phaseExec}, 8'h00);

      // Random traffic with occasional resets
      for (int n = 0; n < 400; n++) begin
         if (n % 60 == 0) rom[$urandom_range(0, 255)] = 8'h70;
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 24) == 0), 8'($urandom_range(0, 255)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed as follows.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 romData  input  8  ROM output at address romAddr.
REQ-005 dbus  input  8  data bus value, used as jump target.
REQ-006 doJumpBar  input  1  from control decode; low = load PC from dbus this EXEC cycle.
REQ-007 assertRom  input  1  from control decode; high = instruction consumes an immediate byte from ROM.
REQ-008 run  input  1  high = free-running; low = pause after current instruction.
REQ-009 step  input  1  single-cycle pulse; releases one instruction while paused.
REQ-010 ir  output  8  instruction register, feeds control decode.
REQ-011 pc  output  8  program counter.
REQ-012 romAddr  output  8  ROM address, equal to pc combinationally.
REQ-013 phaseExec  output  1  high while state is EXEC.
REQ-014 halted  output  1  high while state is HALT.
REQ-015 retired  output  8  count of completed EXEC cycles.

Function
REQ-016 The sequencer SHALL have four states: FETCH, EXEC, PAUSE and HALT, with a registered state.
REQ-017 In FETCH, on the clock edge, ir SHALL load romData, pc SHALL increment, and state SHALL go to EXEC.
REQ-018 In EXEC, if doJumpBar is 0, pc SHALL load dbus.
REQ-019 In EXEC, if doJumpBar is 1 and assertRom is 1, pc SHALL increment by 1.
REQ-020 In EXEC, if doJumpBar is 1 and assertRom is 0, pc SHALL hold.
REQ-021 If doJumpBar is 0 and assertRom is 1 in the same EXEC cycle, the jump SHALL take priority and no increment SHALL occur.
REQ-022 A halt instruction is ir[6:4] == 3'b111; in EXEC, a halt instruction SHALL leave pc unchanged and move state to HALT, ignoring doJumpBar and assertRom.
REQ-023 If EXEC does not hold a halt instruction, the next state SHALL be FETCH when run is 1, otherwise PAUSE.
REQ-024 In PAUSE, state SHALL go to FETCH when run is 1 or step is 1; otherwise pc, ir and retired SHALL hold.
REQ-025 step SHALL be ignored in FETCH, EXEC and HALT.
REQ-026 HALT SHALL be absorbing: pc, ir and retired hold, and only reset leaves HALT.
REQ-027 retired SHALL increment by 1, modulo 256, on every EXEC cycle, including a halt instruction's EXEC cycle.
REQ-028 All pc arithmetic SHALL be 8-bit modulo 256, so 0xFF + 1 wraps to 0x00.
REQ-029 Instruction latency SHALL be exactly 2 cycles (FETCH, then EXEC) when run is held high.
REQ-030 ir SHALL change only in FETCH, so decode inputs stay stable throughout EXEC.
REQ-031 phaseExec and halted SHALL be decoded directly from the state register, with no combinational path from inputs.

Reset
REQ-032 On reset: pc = 0x00, ir = 0x00, retired = 0x00, state = FETCH, phaseExec = 0, halted = 0.
REQ-033 Reset SHALL override every state, including mid-EXEC and HALT, and SHALL take effect on the next clock edge.
REQ-034 In the reset cycle, a low doJumpBar SHALL NOT alter pc.

Verification
REQ-035 Scenario 1: reset, run = 1, ROM = {0x20, 0x30, ...}, doJumpBar = 1, assertRom = 0 -> ir = 0x20 at cycle 1, pc = 0x01; ir = 0x30 at cycle 3, pc = 0x02; retired = 2 after cycle 4.
REQ-036 Scenario 2: in EXEC with pc = 0x05, assertRom = 1 and doJumpBar = 0, dbus = 0x40 -> pc = 0x40, then the next FETCH addresses 0x40.
REQ-037 Scenario 3: pc = 0xFF in FETCH -> pc = 0x00 in EXEC; with assertRom = 1 at pc = 0xFF in EXEC -> pc = 0x00.
REQ-038 Scenario 4: run = 0 -> state is PAUSE after the first EXEC; a one-cycle step pulse -> exactly one FETCH/EXEC pair, then PAUSE again, with retired up by 1.
REQ-039 Scenario 5: ROM byte 0x70 fetched -> halted = 1 after its EXEC cycle, pc frozen, and step/run toggles have no effect; reset -> halted = 0, pc = 0x00.
REQ-040 Scenario 6: reset asserted during EXEC with doJumpBar = 0, dbus = 0x99 -> pc = 0x00 and state = FETCH after the edge.
